mem_port_arbiter: RTL and testbench

//  Shares the single-port MemReadWrite block among three requesters: instruction fetch (0),

---
 rtl/mem_port_arbiter_pkg.sv | 20 ++
 rtl/mem_port_arbiter_picker.sv | 30 +++
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the three-way memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int NUM_REQ = 3;
  localparam int REQ_IF  = 0;   // instruction fetch
  localparam int REQ_LS  = 1;   // load/store
  localparam int REQ_DBG = 2;   // debug / program loader

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Round-robin successor: the requester after the one just served becomes highest priority.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx == 2'(NUM_REQ - 1)) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_picker.sv
// Combinational round-robin picker: first active request at or after ptr, wrapping 2->0.
module mem_port_arbiter_picker
  import mem_port_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [1:0]         idx,
  output logic               any
);

  // Scan requesters starting at the pointer; the first hit wins.
  always_comb begin
    int c;
    c     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      c = int'(ptr) + k;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (!any && req[c]) begin
        any      = 1'b1;
        grant[c] = 1'b1;
        idx      = 2'(c);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory among fetch, load/store and debug requesters.
// One access in flight; round-robin grant; en/done handshake per requester.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_i,
  input  logic [NUM_REQ-1:0]          wen_i,
  input  logic [NUM_REQ*ADDR_W-1:0]   addr_i,
  input  logic [NUM_REQ*DATA_W-1:0]   wdata_i,
  output logic [NUM_REQ-1:0]          done_o,
  output logic [DATA_W-1:0]           rdata_o,
  output logic [NUM_REQ-1:0]          grant_o,
  output logic                        busy_o,
  output logic                        mem_en,
  output logic                        mem_ren,
  output logic                        mem_wen,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_din,
  input  logic [DATA_W-1:0]           mem_dout
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         ptr, gidx;
  logic               wr;
  logic               last;
  logic [NUM_REQ-1:0] pick_grant;
  logic [1:0]         pick_idx;
  logic               pick_any;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic               sel_wen;

  assign last = (cnt == '0);

  mem_port_arbiter_picker u_pick (
    .req   (req_i),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Route the picked requester's operands toward the holding registers.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wen   = 1'b0;
    for (int n = 0; n < NUM_REQ; n++) begin
      if (pick_idx == 2'(n)) begin
        sel_addr  = addr_i[n*ADDR_W +: ADDR_W];
        sel_wdata = wdata_i[n*DATA_W +: DATA_W];
        sel_wen   = wen_i[n];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: IDLE -> ACCESS -> RESP -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (pick_any) state_nxt = ST_ACCESS;
      ST_ACCESS: if (last)     state_nxt = ST_RESP;
      ST_RESP:                 state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; done pulses to the current owner during RESP.
  always_comb begin
    mem_en  = (state == ST_ACCESS);
    busy_o  = (state != ST_IDLE);
    done_o  = (state == ST_RESP) ? grant_o : '0;
    mem_ren = mem_en & ~wr;
    mem_wen = mem_en & wr;
  end

  // Operand latch, latency counter, read capture and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_o  <= '0;
      gidx     <= '0;
      ptr      <= '0;
      wr       <= 1'b0;
      cnt      <= '0;
      mem_addr <= '0;
      mem_din  <= '0;
      rdata_o  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            grant_o  <= pick_grant;
            gidx     <= pick_idx;
            mem_addr <= sel_addr;
            mem_din  <= sel_wdata;
            wr       <= sel_wen;
            cnt      <= CNT_W'(MEM_LAT - 1);
          end
        end
        ST_ACCESS: begin
          if (last) begin
            if (!wr) rdata_o <= mem_dout;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          ptr      <= rr_next(gidx);
          grant_o  <= '0;
          mem_addr <= '0;
          mem_din  <= '0;
          wr       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: MEM_LAT=2 main instance plus a MEM_LAT=1 instance.
module tb_mem_port_arbiter;

  localparam int AW = 16;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main instance (MEM_LAT=2) signals
  logic [2:0]      req, wen;
  logic [3*AW-1:0] addr;
  logic [3*DW-1:0] wdata;
  logic [2:0]      done, grant;
  logic [DW-1:0]   rdata, mem_din, mem_dout;
  logic [AW-1:0]   mem_addr;
  logic            busy, mem_en, mem_ren, mem_wen;

  // Second instance (MEM_LAT=1) signals
  logic [2:0]      breq, bwen;
  logic [3*AW-1:0] baddr;
  logic [3*DW-1:0] bwdata;
  logic [2:0]      b_done, b_grant;
  logic [DW-1:0]   b_rdata, b_mem_din, b_mem_dout;
  logic [AW-1:0]   b_mem_addr;
  logic            b_busy, b_mem_en, b_mem_ren, b_mem_wen;

  // Memory model for main instance, with a preload port used during reset
  logic [DW-1:0] mem [0:255];
  logic          pl_en;
  logic [7:0]    pl_addr;
  logic [DW-1:0] pl_data;

  always @(posedge clk) begin
    if (mem_wen)    mem[mem_addr[7:0]] <= mem_din;
    else if (pl_en) mem[pl_addr]       <= pl_data;
  end
  assign mem_dout   = mem_ren ? mem[mem_addr[7:0]] : 32'h0;
  assign b_mem_dout = b_mem_ren ? {16'hB000, b_mem_addr} : 32'h0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(2)) dut (
    .clk(clk), .rst(rst), .req_i(req), .wen_i(wen), .addr_i(addr), .wdata_i(wdata),
    .done_o(done), .rdata_o(rdata), .grant_o(grant), .busy_o(busy),
    .mem_en(mem_en), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .req_i(breq), .wen_i(bwen), .addr_i(baddr), .wdata_i(bwdata),
    .done_o(b_done), .rdata_o(b_rdata), .grant_o(b_grant), .busy_o(b_busy),
    .mem_en(b_mem_en), .mem_ren(b_mem_ren), .mem_wen(b_mem_wen),
    .mem_addr(b_mem_addr), .mem_din(b_mem_din), .mem_dout(b_mem_dout)
  );

  int checks   = 0;
  int failures = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    tick();
    pl_en   = 1'b0;
  endtask

  // Called in an IDLE cycle with requests already set; walks one MEM_LAT=2 access
  // and ends in the following IDLE cycle.
  task automatic serve(input string tag, input logic [2:0] g, input logic w,
                       input logic [15:0] a, input logic [31:0] rd, input logic [2:0] clr);
    tick();
    chk({tag, ".grant"},   32'(grant),   32'(g));
    chk({tag, ".mem_en1"}, 32'(mem_en),  32'd1);
    chk({tag, ".mem_wen"}, 32'(mem_wen), 32'(w));
    chk({tag, ".mem_ren"}, 32'(mem_ren), 32'(!w));
    chk({tag, ".addr"},    32'(mem_addr), 32'(a));
    chk({tag, ".busy"},    32'(busy),    32'd1);
    tick();
    chk({tag, ".mem_en2"}, 32'(mem_en),  32'd1);
    chk({tag, ".nodone"},  32'(done),    32'd0);
    tick();
    chk({tag, ".done"},    32'(done),    32'(g));
    chk({tag, ".rdata"},   rdata,        rd);
    chk({tag, ".en_off"},  32'(mem_en),  32'd0);
    req = req & ~clr;
    tick();
    chk({tag, ".done_end"}, 32'(done),   32'd0);
    chk({tag, ".idle"},     32'(busy),   32'd0);
    chk({tag, ".grant0"},   32'(grant),  32'd0);
  endtask

  initial begin
    req = '0; wen = '0; addr = '0; wdata = '0;
    breq = '0; bwen = '0; baddr = '0; bwdata = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    rst = 1'b1;

    // Reset with memory preload
    tick();
    preload(8'h10, 32'h1234_5678);
    preload(8'h40, 32'hB2B2_B2B2);
    preload(8'h50, 32'hC3C3_C3C3);
    chk("rst.grant", 32'(grant), 32'd0);
    chk("rst.busy",  32'(busy),  32'd0);
    chk("rst.mem_en", 32'(mem_en), 32'd0);
    chk("rst.done",  32'(done),  32'd0);
    chk("rst.rdata", rdata,      32'd0);
    chk("rst.addr",  32'(mem_addr), 32'd0);
    rst = 1'b0;

    // 1: single IF read
    addr[0*AW +: AW] = 16'h0010;
    req = 3'b001;
    serve("t1", 3'b001, 1'b0, 16'h0010, 32'h1234_5678, 3'b001);

    // 2: all three request right after reset -> 0,1,2, done every 4 cycles
    rst = 1'b1;
    tick();
    rst = 1'b0;
    addr[1*AW +: AW] = 16'h0040;
    addr[2*AW +: AW] = 16'h0050;
    req = 3'b111;
    serve("t2a", 3'b001, 1'b0, 16'h0010, 32'h1234_5678, 3'b001);
    serve("t2b", 3'b010, 1'b0, 16'h0040, 32'hB2B2_B2B2, 3'b010);
    serve("t2c", 3'b100, 1'b0, 16'h0050, 32'hC3C3_C3C3, 3'b100);

    // 3: req0 and req1 held continuously -> alternate 0,1,0,1
    req = 3'b011;
    serve("t3a", 3'b001, 1'b0, 16'h0010, 32'h1234_5678, 3'b000);
    serve("t3b", 3'b010, 1'b0, 16'h0040, 32'hB2B2_B2B2, 3'b000);
    serve("t3c", 3'b001, 1'b0, 16'h0010, 32'h1234_5678, 3'b000);
    serve("t3d", 3'b010, 1'b0, 16'h0040, 32'hB2B2_B2B2, 3'b011);

    // 4: LS write, rdata unchanged; then IF reads it back
    addr[1*AW +: AW]  = 16'h0020;
    wdata[1*DW +: DW] = 32'hDEAD_BEEF;
    wen = 3'b010;
    req = 3'b010;
    serve("t4w", 3'b010, 1'b1, 16'h0020, 32'hB2B2_B2B2, 3'b010);
    wen = 3'b000;
    addr[0*AW +: AW] = 16'h0020;
    req = 3'b001;
    serve("t4r", 3'b001, 1'b0, 16'h0020, 32'hDEAD_BEEF, 3'b001);

    // 5: reset during second ACCESS cycle, then pointer restarts at requester 0
    addr[1*AW +: AW] = 16'h0040;
    req = 3'b010;
    tick();
    chk("t5.grant", 32'(grant), 32'b010);
    tick();
    chk("t5.acc2", 32'(mem_en), 32'd1);
    rst = 1'b1;
    tick();
    chk("t5.mem_en", 32'(mem_en), 32'd0);
    chk("t5.grant0", 32'(grant),  32'd0);
    chk("t5.busy",   32'(busy),   32'd0);
    chk("t5.done",   32'(done),   32'd0);
    rst = 1'b0;
    addr[0*AW +: AW] = 16'h0010;
    req = 3'b011;
    serve("t5a", 3'b001, 1'b0, 16'h0010, 32'h1234_5678, 3'b001);
    serve("t5b", 3'b010, 1'b0, 16'h0040, 32'hB2B2_B2B2, 3'b010);

    // 6: MEM_LAT=1 instance, single debug read -> done 2 cycles after sample
    baddr[2*AW +: AW] = 16'h0077;
    breq = 3'b100;
    tick();
    chk("t6.grant",  32'(b_grant),  32'b100);
    chk("t6.mem_en", 32'(b_mem_en), 32'd1);
    chk("t6.nodone", 32'(b_done),   32'd0);
    tick();
    chk("t6.done",   32'(b_done),   32'b100);
    chk("t6.rdata",  b_rdata,       32'hB000_0077);
    chk("t6.en_off", 32'(b_mem_en), 32'd0);
    breq = 3'b000;
    tick();
    chk("t6.done_end", 32'(b_done), 32'd0);
    chk("t6.idle",     32'(b_busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
